// File: rtl/tt_pkg.sv
// Shared constants and FSM state type for the truth-table sweep checker.
package tt_pkg;

    localparam int N_IN  = 7;
    localparam int TT_W  = 128;
    localparam int IDX_W = 7;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/tt_idx_delay.sv
// Valid + vector-index delay line that aligns each sampled function output
// with the vector that produced it. DEPTH counts the undelayed input as stage 0.
module tt_idx_delay
    import tt_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    generate
        if (DEPTH <= 1) begin : g_pass
            assign vld_o = vld_i;
            assign idx_o = idx_i;
        end else begin : g_line
            localparam int unsigned NST = DEPTH - 1;

            logic [NST-1:0]   vld_q;
            logic [IDX_W-1:0] idx_q [NST];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int unsigned s = 0; s < NST; s++) begin
                        idx_q[s] <= '0;
                    end
                end else begin
                    vld_q[0] <= vld_i;
                    idx_q[0] <= idx_i;
                    for (int unsigned s = 1; s < NST; s++) begin
                        vld_q[s] <= vld_q[s-1];
                        idx_q[s] <= idx_q[s-1];
                    end
                end
            end

            assign vld_o = vld_q[NST-1];
            assign idx_o = idx_q[NST-1];
        end
    endgenerate

endmodule

// File: rtl/tt_sweep_checker.sv
// Sweeps all 128 input vectors through a 7-input function block, harvests its
// truth table and compares it bit by bit against a latched golden table.
module tt_sweep_checker #(
    parameter int N_IN    = 7,
    parameter int DUT_LAT = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic [tt_pkg::TT_W-1:0] expected_i,
    output logic [N_IN-1:0]         x_o,
    input  logic                    dut_out_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [tt_pkg::TT_W-1:0] tt_o,
    output logic                    match_o,
    output logic [tt_pkg::CNT_W-1:0] mism_cnt_o,
    output logic [tt_pkg::IDX_W-1:0] first_mism_o,
    output logic                    first_mism_vld_o
);
    import tt_pkg::*;

    state_t            state, state_nxt;
    logic [N_IN-1:0]   vec;
    logic [TT_W-1:0]   exp_q;
    logic              samp_vld;
    logic [IDX_W-1:0]  samp_idx;
    logic              accept, last, miss;
    logic [CNT_W-1:0]  cnt_nxt;

    assign accept  = (state == IDLE) && start_i;
    assign last    = samp_vld && (samp_idx == IDX_W'(TT_W - 1));
    assign miss    = samp_vld && (dut_out_i != exp_q[samp_idx]);
    assign cnt_nxt = mism_cnt_o + CNT_W'(miss);
    assign x_o     = vec;

    tt_idx_delay #(
        .DEPTH(DUT_LAT + 1)
    ) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (state == SWEEP),
        .idx_i (IDX_W'(vec)),
        .vld_o (samp_vld),
        .idx_o (samp_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Completion keys off the last sample landing, so SWEEP exits straight to
    // IDLE when there is no latency and via DRAIN otherwise.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = SWEEP;
            SWEEP: begin
                if (last)           state_nxt = IDLE;
                else if (vec == '1) state_nxt = DRAIN;
            end
            DRAIN:   if (last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec <= '0;
        end else if (state_nxt == IDLE) begin
            vec <= '0;
        end else if (state == SWEEP && vec != '1) begin
            vec <= vec + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_q            <= '0;
            tt_o             <= '0;
            done_o           <= 1'b0;
            match_o          <= 1'b0;
            mism_cnt_o       <= '0;
            first_mism_o     <= '0;
            first_mism_vld_o <= 1'b0;
        end else begin
            done_o <= last;
            if (accept) begin
                exp_q            <= expected_i;
                tt_o             <= '0;
                match_o          <= 1'b0;
                mism_cnt_o       <= '0;
                first_mism_o     <= '0;
                first_mism_vld_o <= 1'b0;
            end else if (samp_vld) begin
                tt_o[samp_idx] <= dut_out_i;
                if (miss) begin
                    mism_cnt_o <= cnt_nxt;
                    if (!first_mism_vld_o) begin
                        first_mism_o     <= samp_idx;
                        first_mism_vld_o <= 1'b1;
                    end
                end
                if (last) match_o <= (cnt_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: two instances (latency 0 and 1) share stimulus
// and are checked against a truth-table-level reference model.
module tb_tt_sweep_checker;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] expv;

    logic [6:0]   x0, x1;
    logic         d0, d1, busy0, busy1, done0, done1;
    logic [127:0] tt0, tt1;
    logic         match0, match1, fv0, fv1;
    logic [7:0]   cnt0, cnt1;
    logic [6:0]   fm0, fm1;

    int           errors = 0;
    int           checks = 0;
    int           fn = 0;
    bit           regd = 1'b0;
    int           cur = 0;
    logic [127:0] rtab = '0;
    logic         f0r, f1r;

    logic [127:0] o_tt;
    logic [7:0]   o_cnt;
    logic [6:0]   o_fm, o_x;
    logic         o_match, o_fv, o_busy, o_done;

    always #5 clk = ~clk;

    function automatic logic fval(int f, logic [6:0] x);
        case (f)
            1:       return x[0];
            2:       return x[6];
            3:       return (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
            4:       return rtab[x];
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        f0r <= fval(fn, x0);
        f1r <= fval(fn, x1);
    end
    assign d0 = regd ? f0r : fval(fn, x0);
    assign d1 = regd ? f1r : fval(fn, x1);

    always_comb begin
        o_tt    = cur != 0 ? tt1    : tt0;
        o_cnt   = cur != 0 ? cnt1   : cnt0;
        o_fm    = cur != 0 ? fm1    : fm0;
        o_x     = cur != 0 ? x1     : x0;
        o_match = cur != 0 ? match1 : match0;
        o_fv    = cur != 0 ? fv1    : fv0;
        o_busy  = cur != 0 ? busy1  : busy0;
        o_done  = cur != 0 ? done1  : done0;
    end

    tt_sweep_checker #(.N_IN(7), .DUT_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .expected_i(expv),
        .x_o(x0), .dut_out_i(d0), .busy_o(busy0), .done_o(done0), .tt_o(tt0),
        .match_o(match0), .mism_cnt_o(cnt0), .first_mism_o(fm0),
        .first_mism_vld_o(fv0)
    );

    tt_sweep_checker #(.N_IN(7), .DUT_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start), .expected_i(expv),
        .x_o(x1), .dut_out_i(d1), .busy_o(busy1), .done_o(done1), .tt_o(tt1),
        .match_o(match1), .mism_cnt_o(cnt1), .first_mism_o(fm1),
        .first_mism_vld_o(fv1)
    );

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Harvested vector i sees f(i + lat - fdelay), with x held at 0 before the
    // sweep and at 127 after it.
    function automatic logic [127:0] harvest(int f, bit rg, int lat);
        logic [127:0] r;
        int j;
        for (int i = 0; i < 128; i++) begin
            j = i + lat - (rg ? 1 : 0);
            if (j < 0)   j = 0;
            if (j > 127) j = 127;
            r[i] = fval(f, 7'(j));
        end
        return r;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!o_done && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", {127'd0, o_done}, 128'd1);
    endtask

    task automatic run_check(input string nm, input logic [127:0] ett, input bit em,
                             input int ec, input int ef, input bit efv, input int ecyc);
        int k;
        pulse_start();
        wait_done(k);
        chk({nm, "_cycles"}, 128'(k + 1), 128'(ecyc));
        chk({nm, "_tt"},     o_tt, ett);
        chk({nm, "_match"},  {127'd0, o_match}, {127'd0, em});
        chk({nm, "_cnt"},    128'(o_cnt), 128'(ec));
        chk({nm, "_first"},  128'(o_fm), 128'(ef));
        chk({nm, "_fvld"},   {127'd0, o_fv}, {127'd0, efv});
        chk({nm, "_busy"},   {127'd0, o_busy}, 128'd0);
        @(negedge clk);
        chk({nm, "_done1cyc"}, {127'd0, o_done}, 128'd0);
        chk({nm, "_hold"},   o_tt, ett);
    endtask

    task automatic model_check(input string nm);
        logic [127:0] h, d;
        int c, fi;
        h  = harvest(fn, regd, cur);
        d  = h ^ expv;
        c  = 0;
        fi = -1;
        for (int i = 0; i < 128; i++) begin
            if (d[i]) begin
                c++;
                if (fi < 0) fi = i;
            end
        end
        run_check(nm, h, c == 0, c, fi < 0 ? 0 : fi, fi >= 0, 129 + cur);
    endtask

    typedef struct {
        int           fn;
        bit           regd;
        int           sel;
        logic [127:0] expv;
        logic [127:0] tt;
        bit           match;
        int           cnt;
        int           first;
        bit           fvld;
        int           cyc;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int k, nd;
        logic [127:0] maj;

        maj = {16{8'hE8}};
        tbl[0] = '{0, 1'b0, 0, '0, '0, 1'b1, 0, 0, 1'b0, 129};
        tbl[1] = '{1, 1'b0, 0, '0, {32{4'hA}}, 1'b0, 64, 1, 1'b1, 129};
        tbl[2] = '{2, 1'b1, 1, {64'hFFFF_FFFF_FFFF_FFFF, 64'd0},
                   {64'hFFFF_FFFF_FFFF_FFFF, 64'd0}, 1'b1, 0, 0, 1'b0, 130};
        tbl[3] = '{2, 1'b1, 0, {64'hFFFF_FFFF_FFFF_FFFF, 64'd0},
                   {64'hFFFF_FFFF_FFFF_FFFE, 64'd0}, 1'b0, 1, 64, 1'b1, 129};
        tbl[4] = '{3, 1'b0, 0, {1'b0, maj[126:0]}, maj, 1'b0, 1, 127, 1'b1, 129};

        rst_n = 1'b0;
        start = 1'b0;
        expv  = '0;
        repeat (3) @(negedge clk);
        chk("rst_x",     128'(x0), 128'd0);
        chk("rst_busy",  {127'd0, busy0}, 128'd0);
        chk("rst_done",  {127'd0, done0}, 128'd0);
        chk("rst_tt",    tt0, 128'd0);
        chk("rst_match", {127'd0, match1}, 128'd0);
        chk("rst_cnt",   128'(cnt1), 128'd0);
        chk("rst_fm",    128'(fm0), 128'd0);
        chk("rst_fvld",  {127'd0, fv0}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            fn   = tbl[i].fn;
            regd = tbl[i].regd;
            cur  = tbl[i].sel;
            expv = tbl[i].expv;
            repeat (2) @(negedge clk);
            run_check($sformatf("tbl%0d", i), tbl[i].tt, tbl[i].match, tbl[i].cnt,
                      tbl[i].first, tbl[i].fvld, tbl[i].cyc);
        end

        // Start while busy at x=40 is ignored; exactly one done follows.
        fn = 1; regd = 1'b0; cur = 0; expv = '0;
        @(negedge clk);
        pulse_start();
        k = 0;
        while (x0 != 7'd40 && k < 200) begin
            @(negedge clk);
            k++;
        end
        pulse_start();
        chk("ign_x41", 128'(x0), 128'd41);
        @(negedge clk);
        chk("ign_x42", 128'(x0), 128'd42);
        nd = 0;
        for (int c = 0; c < 250; c++) begin
            if (done0) nd++;
            @(negedge clk);
        end
        chk("ign_ndone", 128'(nd), 128'd1);
        chk("ign_cnt",   128'(cnt0), 128'd64);

        // Back-to-back: start presented in the done cycle is accepted.
        pulse_start();
        wait_done(k);
        chk("b2b_cnt_a", 128'(cnt0), 128'd64);
        start = 1'b1;
        fn    = 0;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {127'd0, busy0}, 128'd1);
        chk("b2b_x",    128'(x0), 128'd0);
        chk("b2b_clr",  {tt0[126:0], match0}, 128'd0);
        chk("b2b_cnt",  128'({fv0, cnt0}), 128'd0);
        chk("b2b_done", {127'd0, done0}, 128'd0);
        wait_done(k);
        chk("b2b_cycles", 128'(k + 1), 128'd129);
        chk("b2b_match",  {127'd0, match0}, 128'd1);
        @(negedge clk);

        // Reset mid-sweep at x=50.
        fn = 1;
        pulse_start();
        k = 0;
        while (x0 != 7'd50 && k < 200) begin
            @(negedge clk);
            k++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_x",    128'({x1, x0}), 128'd0);
        chk("mrst_busy", {126'd0, busy1, busy0}, 128'd0);
        chk("mrst_done", {126'd0, done1, done0}, 128'd0);
        chk("mrst_tt",   tt0 | tt1, 128'd0);
        chk("mrst_res",  128'({match0, match1, cnt0, cnt1, fm0, fm1, fv0, fv1}), 128'd0);
        nd = 0;
        for (int c = 0; c < 200; c++) begin
            if (done0 || done1) nd++;
            @(negedge clk);
        end
        chk("mrst_nodone", 128'(nd), 128'd0);
        run_check("post_rst", {32{4'hA}}, 1'b0, 64, 1, 1'b1, 129);

        // Random truth tables, latencies and expected-table corruptions.
        for (int r = 0; r < 8; r++) begin
            int nflip;
            rtab  = {$urandom, $urandom, $urandom, $urandom};
            fn    = 4;
            regd  = 1'($urandom_range(0, 1));
            cur   = int'($urandom_range(0, 1));
            expv  = harvest(fn, regd, cur);
            nflip = int'($urandom_range(0, 3));
            for (int f = 0; f < nflip; f++) begin
                int p;
                p = int'($urandom_range(0, 127));
                expv[p] = ~expv[p];
            end
            repeat (2) @(negedge clk);
            model_check($sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
